// File: rtl/uart_rx_fifo_if.sv
// Serial line and FIFO read-side bundle of uart_rx_fifo; the receiver sits on
// the slave modport, the line driver/reader on the master modport.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        rxd;
    logic                        rdn;
    logic [7:0]                  d_out;
    logic                        r_ready;
    logic                        parity_error;
    logic                        frame_error;
    logic                        overrun;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output rxd, rdn,
        input  d_out, r_ready, parity_error, frame_error, overrun, busy, fifo_count
    );

    modport slave (
        input  rxd, rdn,
        output d_out, r_ready, parity_error, frame_error, overrun, busy, fifo_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a small status-tagged FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote at ticks 7/8/9.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk16x,
    input  logic          clrn,
    uart_rx_fifo_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_T = 4'd9;
`else
    localparam logic [3:0] DECIDE_T = 4'd8;
`endif
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == 1)      return ^{d, p};
        else if (PARITY == 2) return ~(^{d, p});
        else                  return 1'b0;
    endfunction

    state_t                 r_state;
    logic [3:0]             r_tick;
    logic [2:0]             r_bitcnt;
    logic                   r_push;
    logic                   r_sync_p0, r_sync_p1, r_rxs_d;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par, r_ferr;
    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [PW:0]            r_count;
    logic                   r_overrun;
    logic                   w_rxs, w_bit, w_decide, w_wrap;
    logic                   w_empty, w_full, w_pop, w_wr, w_drop;
    logic [EW-1:0]          w_head;

    // Stage p0/p1: line synchroniser, plus the previous synchronised value for edge detect
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_sync_p0 <= bus.rxd;
            r_sync_p1 <= r_sync_p0;
            r_rxs_d   <= r_sync_p1;
        end
    end

    assign w_rxs    = r_sync_p1;
    assign w_decide = (r_tick == DECIDE_T);
    assign w_wrap   = (r_tick == 4'hF);

`ifdef UART_RX_MAJORITY_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic r_s7, r_s8;
    always_ff @(posedge clk16x) begin
        if (r_tick == 4'd7) r_s7 <= w_rxs;
        if (r_tick == 4'd8) r_s8 <= w_rxs;
    end
    assign w_bit = majority3(r_s7, r_s8, w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_state  <= S_IDLE;
            r_tick   <= 4'd0;
            r_bitcnt <= 3'd0;
            r_push   <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_tick <= r_tick + 4'd1;
            case (r_state)
                S_IDLE: begin
                    r_tick   <= 4'd0;
                    r_bitcnt <= 3'd0;
                    if (!w_rxs && r_rxs_d) r_state <= S_START;
                end
                S_START: begin
                    if (w_decide && w_bit) r_state <= S_IDLE;
                    else if (w_wrap)       r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_wrap) begin
                        if (r_bitcnt == LAST_DATA) begin
                            r_bitcnt <= 3'd0;
                            r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_wrap) r_state <= S_STOP;
                end
                S_STOP: begin
                    // Push cycle: a line still low here is a break, so wait it out
                    if (r_push) begin
                        r_bitcnt <= 3'd0;
                        r_state  <= w_rxs ? S_IDLE : S_BREAK;
                    end else if (w_decide && r_bitcnt == LAST_STOP) begin
                        r_push <= 1'b1;
                    end else if (w_wrap) begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                S_BREAK: begin
                    r_tick <= 4'd0;
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk16x) begin
        if (r_state == S_START) r_ferr <= 1'b0;
        if (w_decide) begin
            case (r_state)
                S_DATA:   r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                S_PARITY: r_par   <= w_bit;
                S_STOP:   if (!w_bit) r_ferr <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !bus.rdn && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    always_ff @(posedge clk16x) begin
        if (w_wr) r_mem[r_wptr] <= {r_ferr, parity_err(r_shift, r_par), r_shift};
    end

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A full-FIFO push that rides along with a pop leaves the flag alone
            if (w_drop)
                r_overrun <= 1'b1;
            else if (!bus.rdn && !(r_push && w_full && w_pop))
                r_overrun <= 1'b0;
        end
    end

    always_comb begin
        w_head           = r_mem[r_rptr];
        bus.d_out        = '0;
        bus.parity_error = 1'b0;
        bus.frame_error  = 1'b0;
        if (!w_empty) begin
            bus.d_out[DATA_BITS-1:0] = w_head[DATA_BITS-1:0];
            bus.parity_error         = w_head[DATA_BITS];
            bus.frame_error          = w_head[DATA_BITS+1];
        end
    end

    assign bus.r_ready    = !w_empty;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.fifo_count = r_count;
endmodule
